// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the Forth core execute stage.
// Provides the stack op encoding, its decoder from the change/dec/update
// controls, and the state encoding of the stack spill/fill engine.
package cpu_pkg;

   typedef enum logic [1:0] {
      HOLD,
      PUSH,
      POP,
      UPDATE
   } stack_op_t;

   typedef enum logic [1:0] {
      IDLE,
      SPILL,
      FILL
   } spill_state_t;

   function automatic stack_op_t decode_op(
      input logic change,
      input logic dec,
      input logic update
   );
      stack_op_t op;
      op = HOLD;
      if (change) begin
         op = dec ? POP : PUSH;
      end else if (update) begin
         op = UPDATE;
      end
      return op;
   endfunction

endpackage

// File: rtl/stack_ring.sv
// stack_ring: DEPTH x WIDTH register ring holding the newest stack entries.
// Ports: bot/count locate the live window; top_data/bot_data read the
// newest/oldest entry; push writes above top, update overwrites top,
// fill writes the slot just below bot. Indices wrap modulo DEPTH.
module stack_ring
   import cpu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic [$clog2(DEPTH)-1:0] bot,
   input  logic [$clog2(DEPTH):0]   count,
   input  logic                     push,
   input  logic                     update,
   input  logic [WIDTH-1:0]         data,
   input  logic                     fill,
   input  logic [WIDTH-1:0]         fill_data,
   output logic [WIDTH-1:0]         top_data,
   output logic [WIDTH-1:0]         bot_data
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] ONE = AW'(1);

   logic [WIDTH-1:0] ring [DEPTH];
   logic [AW-1:0]    above;
   logic [AW-1:0]    top;
   logic [AW-1:0]    below;

   // AW-bit arithmetic wraps modulo DEPTH (DEPTH is a power of two)
   assign above = bot + count[AW-1:0];
   assign top   = above - ONE;
   assign below = bot - ONE;

   assign top_data = ring[top];
   assign bot_data = ring[bot];

   always_ff @(posedge clk) begin
      if (push) begin
         ring[above] <= data;
      end
      if (update) begin
         ring[top] <= data;
      end
      if (fill) begin
         ring[below] <= fill_data;
      end
   end

endmodule

// File: rtl/spill_stack.sv
// spill_stack: Forth stack with an on-chip ring that spills its oldest
// entries to a backing memory and refills them in the background.
// Ports: D/change/dec/update CPU op in, Q top out, stall hold request,
// sticky overflow/underflow, depth total entries, mem_* transfer port.
module spill_stack
   import cpu_pkg::*;
#(
   parameter int                     WIDTH       = 16,
   parameter int                     DEPTH       = 8,
   parameter int                     MADDR_WIDTH = 8,
   parameter logic [MADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                     LOW_WATER   = 2,
   parameter int                     HIGH_WATER  = DEPTH - 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       D,
   input  logic                   change,
   input  logic                   dec,
   input  logic                   update,
   output logic [WIDTH-1:0]       Q,
   output logic                   stall,
   output logic                   overflow,
   output logic                   underflow,
   output logic [MADDR_WIDTH+1:0] depth,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [MADDR_WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0]       mem_wdata,
   input  logic                   mem_ack,
   input  logic [WIDTH-1:0]       mem_rdata
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = MADDR_WIDTH + 1;
   localparam int DW = MADDR_WIDTH + 2;

   localparam logic [CW-1:0] C_FULL   = CW'(DEPTH);
   localparam logic [CW-1:0] C_ALMOST = CW'(DEPTH - 1);
   localparam logic [CW-1:0] C_ONE    = CW'(1);
   localparam logic [CW-1:0] C_LOW    = CW'(LOW_WATER);
   localparam logic [CW-1:0] C_HIGH   = CW'(HIGH_WATER);
   localparam logic [SW-1:0] S_FULL   = SW'(2 ** MADDR_WIDTH);
   localparam logic [SW-1:0] S_ONE    = SW'(1);
   localparam logic [AW-1:0] B_ONE    = AW'(1);
   localparam logic [MADDR_WIDTH-1:0] A_ONE = MADDR_WIDTH'(1);

   spill_state_t   state;
   spill_state_t   state_n;
   logic [CW-1:0]  count;
   logic [CW-1:0]  count_n;
   logic [SW-1:0]  sp;
   logic [SW-1:0]  sp_n;
   logic [AW-1:0]  bot;
   logic [AW-1:0]  bot_n;

   stack_op_t      op;
   logic           is_push;
   logic           is_pop;
   logic           is_upd;
   logic           empty;
   logic           full;
   logic           ovf_hit;
   logic           unf_hit;
   logic           push_do;
   logic           pop_do;
   logic           upd_do;
   logic           spill_done;
   logic           fill_done;
   logic [WIDTH-1:0] top_data;
   logic [WIDTH-1:0] bot_data;

   stack_ring #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ring (
      .clk       (clk),
      .bot       (bot),
      .count     (count),
      .push      (push_do),
      .update    (upd_do),
      .data      (D),
      .fill      (fill_done),
      .fill_data (mem_rdata),
      .top_data  (top_data),
      .bot_data  (bot_data)
   );

   always_comb begin
      op         = decode_op(change, dec, update);
      is_push    = (op == PUSH);
      is_pop     = (op == POP);
      is_upd     = (op == UPDATE);
      spill_done = (state == SPILL) && mem_ack;
      fill_done  = (state == FILL) && mem_ack;
      // ring[bot] is already handed to memory while spilling
      empty = (state == SPILL) ? (count == C_ONE) : (count == '0);
      // a fill owns the slot below bot until it lands
      full = (count == C_FULL) ||
             ((state == FILL) && (count == C_ALMOST));
      ovf_hit = is_push && (count == C_FULL) && (sp == S_FULL);
      unf_hit = (is_pop || is_upd) && (count == '0) &&
                (sp == '0) && (state == IDLE);
      stall = ((is_pop || is_upd) && empty &&
               ((sp != '0) || (state == SPILL))) ||
              (is_push && full && !ovf_hit);
      push_do = is_push && !stall && !ovf_hit;
      pop_do  = is_pop && !stall && !unf_hit;
      upd_do  = is_upd && !stall && !unf_hit;

      count_n = count;
      if (push_do)    count_n = count_n + C_ONE;
      if (fill_done)  count_n = count_n + C_ONE;
      if (pop_do)     count_n = count_n - C_ONE;
      if (spill_done) count_n = count_n - C_ONE;

      sp_n  = sp;
      bot_n = bot;
      if (spill_done) begin
         sp_n  = sp + S_ONE;
         bot_n = bot + B_ONE;
      end
      if (fill_done) begin
         sp_n  = sp - S_ONE;
         bot_n = bot - B_ONE;
      end
   end

   // Watermarks are judged on registered count only
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if ((count > C_HIGH) && (sp < S_FULL)) begin
               state_n = SPILL;
            end else if ((count < C_LOW) && (sp != '0)) begin
               state_n = FILL;
            end
         end
         SPILL, FILL: begin
            if (mem_ack) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         count     <= '0;
         sp        <= '0;
         bot       <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= BASE_ADDR;
         mem_wdata <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         state <= state_n;
         count <= count_n;
         sp    <= sp_n;
         bot   <= bot_n;
         if (ovf_hit) overflow <= 1'b1;
         if (unf_hit) underflow <= 1'b1;
         // request fields are frozen on entry and held until ack
         if ((state == IDLE) && (state_n == SPILL)) begin
            mem_we    <= 1'b1;
            mem_addr  <= BASE_ADDR + sp[MADDR_WIDTH-1:0];
            mem_wdata <= bot_data;
         end
         if ((state == IDLE) && (state_n == FILL)) begin
            mem_we   <= 1'b0;
            mem_addr <= BASE_ADDR + sp[MADDR_WIDTH-1:0] - A_ONE;
         end
      end
   end

   assign mem_req = (state != IDLE);
   assign Q       = (count == '0) ? '0 : top_data;
   assign depth   = DW'(count) + DW'(sp);

endmodule

// File: tb/tb_spill_stack.sv
// tb_spill_stack: self-checking bench for spill_stack with a small
// backing memory model (2-cycle ack) and a reference stack scoreboard.
module tb_spill_stack;

   logic        clk;
   logic        reset;
   logic [15:0] D;
   logic        change;
   logic        dec;
   logic        update;
   logic [15:0] Q;
   logic        stall;
   logic        overflow;
   logic        underflow;
   logic [4:0]  depth;
   logic        mem_req;
   logic        mem_we;
   logic [2:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ack;
   logic [15:0] mem_rdata;

   logic        ack_auto;
   logic        ack_man;
   logic        auto_en;
   int          lat;
   logic [15:0] mem [8];

   logic [15:0] stk[$];
   logic [15:0] sb[$];
   logic [2:0]  wr_addr[$];
   logic [15:0] wr_data[$];
   logic [2:0]  rd_addr[$];

   int checks = 0;
   int errors = 0;
   int stalls = 0;

   spill_stack #(
      .WIDTH       (16),
      .DEPTH       (4),
      .MADDR_WIDTH (3),
      .BASE_ADDR   (3'd0),
      .LOW_WATER   (1),
      .HIGH_WATER  (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .D         (D),
      .change    (change),
      .dec       (dec),
      .update    (update),
      .Q         (Q),
      .stall     (stall),
      .overflow  (overflow),
      .underflow (underflow),
      .depth     (depth),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_ack = ack_auto | ack_man;

   initial begin
      ack_auto  = 1'b0;
      lat       = 0;
      mem_rdata = '0;
   end

   // memory: ack on the second cycle a request is seen
   always @(posedge clk) begin
      ack_auto <= 1'b0;
      if (auto_en && mem_req && !ack_auto) begin
         if (lat == 1) begin
            ack_auto <= 1'b1;
            lat <= 0;
            if (mem_we) begin
               mem[mem_addr] <= mem_wdata;
               wr_addr.push_back(mem_addr);
               wr_data.push_back(mem_wdata);
            end else begin
               mem_rdata <= mem[mem_addr];
               rd_addr.push_back(mem_addr);
            end
         end else begin
            lat <= lat + 1;
         end
      end else begin
         lat <= 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      stk.delete();
      sb.delete();
      wr_addr.delete();
      wr_data.delete();
      rd_addr.delete();
   endtask

   // kind: 0 push, 1 pop, 2 update; op is held while stalled
   task automatic op(input int kind, input logic [15:0] val);
      int n;
      n = 0;
      change = (kind != 2);
      dec    = (kind == 1);
      update = (kind == 2);
      D      = val;
      if (kind == 1) sb.push_back(stk[$]);
      else sb.push_back(val);
      @(negedge clk);
      while (stall && n < 40) begin
         n++;
         stalls++;
         @(negedge clk);
      end
      if (stall) check("stall_bound", stall, 0);
      if (kind == 1) check("pop_q", Q, sb.pop_front());
      @(posedge clk);
      #1;
      change = 1'b0;
      dec    = 1'b0;
      update = 1'b0;
      if (kind == 0) stk.push_back(val);
      else if (kind == 1) void'(stk.pop_back());
      else stk[$] = val;
      if (kind != 1) check("top_q", Q, sb.pop_front());
      check("depth", depth, stk.size());
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int n;
      reset   = 1'b1;
      D       = '0;
      change  = 1'b0;
      dec     = 1'b0;
      update  = 1'b0;
      ack_man = 1'b0;
      auto_en = 1'b1;
      @(posedge clk);
      do_reset();

      check("rst_q", Q, 0);
      check("rst_stall", stall, 0);
      check("rst_req", mem_req, 0);
      check("rst_we", mem_we, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_ovf", overflow, 0);
      check("rst_unf", underflow, 0);
      check("rst_depth", depth, 0);

      // push 1..6
      stalls = 0;
      for (int i = 1; i <= 6; i++) op(0, 16'(i));
      check("push_stalled", (stalls > 0), 1);
      check("spill_cnt", (wr_addr.size() >= 2), 1);
      if (wr_addr.size() >= 2) begin
         check("spill0_addr", wr_addr[0], 0);
         check("spill0_data", wr_data[0], 1);
         check("spill1_addr", wr_addr[1], 1);
         check("spill1_data", wr_data[1], 2);
      end

      // pop six times, refilling from memory
      for (int i = 0; i < 6; i++) op(1, 16'h0);
      check("fill_cnt", (rd_addr.size() >= 2), 1);
      if (rd_addr.size() >= 2) begin
         check("fill_prev", rd_addr[$-1], 1);
         check("fill_last", rd_addr[$], 0);
      end
      check("pop_depth", depth, 0);
      check("pop_q0", Q, 0);
      check("pop_req", mem_req, 0);

      // underflow on empty stack
      do_reset();
      change = 1'b1;
      dec    = 1'b1;
      @(negedge clk);
      check("unf_stall", stall, 0);
      @(posedge clk);
      #1;
      change = 1'b0;
      dec    = 1'b0;
      check("unf_flag", underflow, 1);
      check("unf_depth", depth, 0);
      check("unf_q", Q, 0);
      @(posedge clk);
      #1;
      check("unf_sticky", underflow, 1);
      check("unf_ovf", overflow, 0);

      // fill ring and memory, then overflow
      do_reset();
      for (int i = 0; i < 12; i++) op(0, 16'(256 + i));
      check("ovf_pre_req", mem_req, 0);
      change = 1'b1;
      D      = 16'hBEEF;
      @(negedge clk);
      check("ovf_stall", stall, 0);
      @(posedge clk);
      #1;
      change = 1'b0;
      check("ovf_flag", overflow, 1);
      check("ovf_q", Q, 16'h010B);
      check("ovf_depth", depth, 12);
      repeat (3) begin
         @(posedge clk);
         #1;
         check("ovf_noreq", mem_req, 0);
      end
      check("ovf_sticky", overflow, 1);

      // push in the same cycle as a spill ack at count = DEPTH-1
      do_reset();
      auto_en = 1'b0;
      op(0, 16'd1);
      op(0, 16'd2);
      op(0, 16'd3);
      n = 0;
      while (!mem_req && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("sa_req", mem_req, 1);
      check("sa_we", mem_we, 1);
      check("sa_addr", mem_addr, 0);
      check("sa_wdata", mem_wdata, 1);
      @(posedge clk);
      #1;
      change  = 1'b1;
      D       = 16'd4;
      ack_man = 1'b1;
      @(negedge clk);
      check("sa_stall", stall, 0);
      @(posedge clk);
      #1;
      change  = 1'b0;
      ack_man = 1'b0;
      stk.push_back(16'd4);
      check("sa_q", Q, 4);
      check("sa_depth", depth, stk.size());
      check("sa_idle", mem_req, 0);
      @(posedge clk);
      #1;
      check("sa_req2", mem_req, 1);
      check("sa_addr2", mem_addr, 1);
      check("sa_wdata2", mem_wdata, 2);

      // reset in the middle of a spill, late ack ignored
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("rs_req0", mem_req, 0);
      @(posedge clk);
      #1;
      ack_man = 1'b1;
      @(posedge clk);
      #1;
      ack_man = 1'b0;
      check("rs_q", Q, 0);
      check("rs_stall", stall, 0);
      check("rs_req", mem_req, 0);
      check("rs_we", mem_we, 0);
      check("rs_addr", mem_addr, 0);
      check("rs_wdata", mem_wdata, 0);
      check("rs_ovf", overflow, 0);
      check("rs_unf", underflow, 0);
      check("rs_depth", depth, 0);
      @(posedge clk);
      #1;
      check("rs_req_late", mem_req, 0);
      check("rs_depth_late", depth, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
